// File: rtl/display_serializer_pkg.sv
// Shared types and constants for the 7-segment serial display driver:
// FSM state encoding and active-high {g,f,e,d,c,b,a} segment patterns.
package display_serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal codes (10-15) map to a dark digit rather than a glyph.
  function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD to 7-segment decoder; blank forces every segment off.
module seven_seg_decode
  import display_serializer_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) seg = seg_pattern(bcd);
  end

endmodule

// File: rtl/display_serializer.sv
// Serial driver for a chain of 7-segment+DP shift-register digits: snapshot,
// decode, shift out MSD first on serial_out/clk_out, then pulse latch_out.
module display_serializer
  import display_serializer_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int CLK_DIV      = 1,
  parameter int AUTO_REFRESH = 0,
  parameter int LZ_BLANK     = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    serial_out,
  output logic                    clk_out,
  output logic                    latch_out,
  output state_t                  fsm_state
);

  localparam int BITS = 8 * NUM_DIGITS;
  localparam int CW   = $clog2(BITS + 1);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Handshake: start is sampled only in IDLE (never queued); busy is high from
  // LOAD through LATCH; frame_done marks the single IDLE cycle after LATCH, and a
  // start seen in that same cycle launches the next frame immediately.
  state_t          state_q, state_d;
  logic [DW-1:0]   div_q;
  logic [CW-1:0]   bit_q;
  logic            phase_q;
  logic [BITS-1:0] sreg_q;
  logic            done_q;
  logic            div_last;
  logic            bit_last;

  logic [NUM_DIGITS-1:0] blank;
  logic [6:0]            seg [NUM_DIGITS];
  logic [BITS-1:0]       frame_word;

  assign div_last = (div_q == DW'(CLK_DIV - 1));
  assign bit_last = (bit_q == CW'(BITS - 1));

  // Leading-zero run from the MSD; digit 0 is never part of it.
  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = '0;
    if (LZ_BLANK != 0) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        lead     = lead && (digits_bcd[4*i +: 4] == 4'd0);
        blank[i] = lead;
      end
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    seven_seg_decode u_dec (
      .bcd   (digits_bcd[4*i +: 4]),
      .blank (blank[i]),
      .seg   (seg[i])
    );
    assign frame_word[8*i +: 8] = {dp[i] & ~blank[i], seg[i]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if ((AUTO_REFRESH != 0) || start) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (phase_q && div_last && bit_last) state_d = S_LATCH;
      S_LATCH: if (div_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // sreg_q[BITS-1] is the bit on the wire; it advances when a high phase ends,
  // so the new bit appears on the first low cycle of the next bit period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      sreg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_LATCH) && div_last;
      unique case (state_q)
        S_LOAD: begin
          sreg_q  <= en ? frame_word : '0;
          div_q   <= '0;
          bit_q   <= '0;
          phase_q <= 1'b0;
        end
        S_SHIFT: begin
          if (div_last) begin
            div_q   <= '0;
            phase_q <= ~phase_q;
            if (phase_q) begin
              bit_q  <= bit_q + CW'(1);
              sreg_q <= {sreg_q[BITS-2:0], 1'b0};
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_LATCH: div_q <= div_last ? '0 : div_q + DW'(1);
        default: begin
          div_q   <= '0;
          bit_q   <= '0;
          phase_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign clk_out    = (state_q == S_SHIFT) && phase_q;
  assign latch_out  = (state_q == S_LATCH);
  assign serial_out = (state_q == S_SHIFT) && sreg_q[BITS-1];
  assign frame_done = done_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_display_serializer.sv
// Scoreboard bench for display_serializer: three instances (defaults; 4 digits
// with CLK_DIV=3 and blanking; auto-refresh with blanking) on one clock.
module tb_display_serializer;

  logic clk;
  logic a_rst, b_rst, c_rst;

  logic        a_en, a_start;
  logic [23:0] a_digits;
  logic [5:0]  a_dp;
  logic        a_busy, a_done, a_ser, a_clk, a_lat;
  logic [1:0]  a_state;

  logic        b_en, b_start;
  logic [15:0] b_digits;
  logic [3:0]  b_dp;
  logic        b_busy, b_done, b_ser, b_clk, b_lat;
  logic [1:0]  b_state;

  logic        c_en, c_start;
  logic [23:0] c_digits;
  logic [5:0]  c_dp;
  logic        c_busy, c_done, c_ser, c_clk, c_lat;
  logic [1:0]  c_state;

  display_serializer u_a (
    .clk(clk), .reset_n(a_rst), .en(a_en), .start(a_start), .digits_bcd(a_digits),
    .dp(a_dp), .busy(a_busy), .frame_done(a_done), .serial_out(a_ser),
    .clk_out(a_clk), .latch_out(a_lat), .fsm_state(a_state)
  );

  display_serializer #(.NUM_DIGITS(4), .CLK_DIV(3), .LZ_BLANK(1)) u_b (
    .clk(clk), .reset_n(b_rst), .en(b_en), .start(b_start), .digits_bcd(b_digits),
    .dp(b_dp), .busy(b_busy), .frame_done(b_done), .serial_out(b_ser),
    .clk_out(b_clk), .latch_out(b_lat), .fsm_state(b_state)
  );

  display_serializer #(.AUTO_REFRESH(1), .LZ_BLANK(1)) u_c (
    .clk(clk), .reset_n(c_rst), .en(c_en), .start(c_start), .digits_bcd(c_digits),
    .dp(c_dp), .busy(c_busy), .frame_done(c_done), .serial_out(c_ser),
    .clk_out(c_clk), .latch_out(c_lat), .fsm_state(c_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [49:0] exp_q[$];   // {channel[1:0], frame right-aligned in 48 bits}

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  logic [2:0] rs, co, so, lo, bz, dn;
  assign rs = {c_rst,  b_rst,  a_rst};
  assign co = {c_clk,  b_clk,  a_clk};
  assign so = {c_ser,  b_ser,  a_ser};
  assign lo = {c_lat,  b_lat,  a_lat};
  assign bz = {c_busy, b_busy, a_busy};
  assign dn = {c_done, b_done, a_done};

  int bits_of[3] = '{48, 32, 48};
  int cdiv_of[3] = '{1, 3, 1};

  logic [47:0] cap[3];
  logic        cur_bit[3], prev_clk[3], prev_lat[3];
  int          nbits[3], hi_run[3], lat_run[3], lo_cnt[3], hi_bad[3], stab_bad[3];
  int          latch_cnt[3] = '{0, 0, 0};

  // Monitor: rebuilds each frame from clk_out rising edges; checks it at the latch pulse.
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (!rs[c]) begin
        cap[c] = '0; nbits[c] = 0; hi_run[c] = 0; lat_run[c] = 0; lo_cnt[c] = 0;
        hi_bad[c] = 0; stab_bad[c] = 0; prev_clk[c] = 1'b0; prev_lat[c] = 1'b0;
        cur_bit[c] = 1'b0;
      end else begin
        if (co[c] && !prev_clk[c]) begin
          cap[c] = {cap[c][46:0], so[c]};
          nbits[c]++;
          cur_bit[c] = so[c];
        end
        if (co[c]) begin
          hi_run[c]++;
          if (so[c] !== cur_bit[c]) stab_bad[c]++;
        end
        if (!co[c] && prev_clk[c]) begin
          if (hi_run[c] != cdiv_of[c]) hi_bad[c]++;
          hi_run[c] = 0;
        end
        if (bz[c] && !co[c] && !lo[c]) lo_cnt[c]++;
        if (lo[c]) lat_run[c]++;
        if (lo[c] && !prev_lat[c]) begin
          latch_cnt[c]++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ch%0d_unexpected_frame got=%h exp=none", c, cap[c]);
          end else begin
            check($sformatf("ch%0d_frame", c), {14'd0, c[1:0], cap[c]}, {14'd0, exp_q.pop_front()});
          end
          check($sformatf("ch%0d_bit_count", c), nbits[c], bits_of[c]);
          check($sformatf("ch%0d_low_cycles", c), lo_cnt[c], 1 + bits_of[c] * cdiv_of[c]);
          check($sformatf("ch%0d_high_len_errs", c), hi_bad[c], 0);
          check($sformatf("ch%0d_serial_unstable", c), stab_bad[c], 0);
          cap[c] = '0; nbits[c] = 0; lo_cnt[c] = 0; hi_bad[c] = 0; stab_bad[c] = 0;
        end
        if (!lo[c] && prev_lat[c]) begin
          check($sformatf("ch%0d_latch_len", c), lat_run[c], cdiv_of[c]);
          lat_run[c] = 0;
        end
        prev_clk[c] = co[c];
        prev_lat[c] = lo[c];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int ch);
    if (ch == 0) a_start = 1'b1;
    else         b_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int max_cyc, output int cyc);
    cyc = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      cyc++;
      if (dn[ch]) return;
    end
    total++; bad++;
    $display("FAIL ch%0d_done_timeout got=none exp=within_%0d", ch, max_cyc);
  endtask

  task automatic run_a(input string name, input logic [23:0] d, input logic [5:0] p,
                       input logic e, input logic [47:0] exp_frame);
    int cyc;
    a_digits = d; a_dp = p; a_en = e;
    exp_q.push_back({2'd0, exp_frame});
    pulse_start(0);
    wait_done(0, 300, cyc);
    check({name, "_latency"}, 1 + cyc, 99);
    check({name, "_busy_after"}, a_busy, 1'b0);
  endtask

  task automatic run_b(input string name, input logic [15:0] d, input logic [3:0] p,
                       input logic [31:0] exp_frame);
    int cyc;
    b_digits = d; b_dp = p; b_en = 1'b1;
    exp_q.push_back({2'd1, 16'd0, exp_frame});
    pulse_start(1);
    wait_done(1, 500, cyc);
    check({name, "_latency"}, 1 + cyc, 197);
  endtask

  task automatic idle_check(input string name, input int cycles, input int lc0, input int exp_delta);
    int extra;
    extra = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (a_done) extra++;
    end
    check({name, "_extra_done"}, extra, 0);
    check({name, "_latch_delta"}, latch_cnt[0] - lc0, exp_delta);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, lc0;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_en = 1'b1; a_start = 1'b0; a_digits = '0; a_dp = '0;
    b_en = 1'b1; b_start = 1'b0; b_digits = '0; b_dp = '0;
    c_en = 1'b1; c_start = 1'b0; c_digits = '0; c_dp = '0;
    repeat (3) @(negedge clk);
    check("reset_outs_a", {a_busy, a_done, a_ser, a_clk, a_lat, a_state}, 7'd0);
    check("reset_outs_b", {b_busy, b_done, b_ser, b_clk, b_lat, b_state}, 7'd0);
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Defaults: 1..6 with dp on digit 2 (the '4'); en=0 blank frame; 0xA in the LSD.
    run_a("a_123456", 24'h123456, 6'b000100, 1'b1, 48'h065B4FE66D7D);
    run_a("a_en_off", 24'h888888, 6'b111111, 1'b0, 48'h000000000000);
    run_a("a_bcd_a",  24'h12345A, 6'b000001, 1'b1, 48'h065B4F666D80);
    run_a("a_907800", 24'h907800, 6'b100001, 1'b1, 48'hEF3F077F3FBF);

    // start held high: three back-to-back frames, one per frame_done.
    lc0 = latch_cnt[0];
    a_digits = 24'h123456; a_dp = 6'b000100; a_en = 1'b1;
    repeat (3) exp_q.push_back({2'd0, 48'h065B4FE66D7D});
    a_start = 1'b1;
    wait_done(0, 300, cyc);
    wait_done(0, 300, cyc);
    check("a_held_period", cyc, 99);
    wait_done(0, 300, cyc);
    a_start = 1'b0;
    idle_check("a_held", 120, lc0, 3);

    // start pulse while busy is dropped.
    lc0 = latch_cnt[0];
    exp_q.push_back({2'd0, 48'h065B4FE66D7D});
    pulse_start(0);
    repeat (30) @(negedge clk);
    check("a_busy_mid", a_busy, 1'b1);
    pulse_start(0);
    wait_done(0, 300, cyc);
    check("a_busy_ignore_latency", 32 + cyc, 99);
    idle_check("a_busy_ignore", 150, lc0, 1);

    // Async reset at bit 20 aborts the frame without a latch.
    lc0 = latch_cnt[0];
    pulse_start(0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (nbits[0] >= 20) break;
    end
    check("a_reached_bit20", nbits[0], 20);
    #1 a_rst = 1'b0;
    #1 check("a_reset_async_outs", {a_busy, a_done, a_ser, a_clk, a_lat, a_state}, 7'd0);
    repeat (2) @(negedge clk);
    a_rst = 1'b1;
    idle_check("a_after_reset", 10, lc0, 0);
    run_a("a_post_reset", 24'h907800, 6'b100001, 1'b1, 48'hEF3F077F3FBF);

    // 4 digits, CLK_DIV=3, leading-zero blanking.
    run_b("b_0705", 16'h0705, 4'b0000, 32'h00073F6D);
    run_b("b_0000", 16'h0000, 4'b1111, 32'h000000BF);
    run_b("b_1234", 16'h1234, 4'b0010, 32'h065BCF66);

    // Auto refresh with blanking, start held low throughout.
    c_digits = 24'h000705; c_dp = 6'b000000; c_en = 1'b1;
    repeat (3) exp_q.push_back({2'd2, 48'h000000073F6D});
    c_rst = 1'b1;
    wait_done(2, 300, cyc);
    wait_done(2, 300, cyc);
    check("c_auto_period1", cyc, 99);
    wait_done(2, 300, cyc);
    c_digits = 24'h000000; c_dp = 6'b111111;
    repeat (2) exp_q.push_back({2'd2, 48'h0000000000BF});
    wait_done(2, 300, cyc);
    check("c_auto_period2", cyc, 99);
    wait_done(2, 300, cyc);
    c_rst = 1'b0;

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
